// File: rtl/keypad_scanner_pkg.sv
// keypad_scanner_pkg: shared FSM state type, keypad geometry and calculator key mapping
package keypad_scanner_pkg;
  localparam int KP_W = 4;
  typedef enum logic [1:0] {ST_SCAN, ST_DEBOUNCE, ST_PRESENT, ST_RELEASE} state_e;
  // Calculator layout, rows top to bottom: 1 2 3 + / 4 5 6 - / 7 8 9 * / C 0 = /
  localparam logic [3:0] KEY_ADD = 4'd3;
  localparam logic [3:0] KEY_SUB = 4'd7;
  localparam logic [3:0] KEY_MUL = 4'd11;
  localparam logic [3:0] KEY_CLR = 4'd12;
  localparam logic [3:0] KEY_ZERO = 4'd13;
  localparam logic [3:0] KEY_EQ = 4'd14;
  localparam logic [3:0] KEY_DIV = 4'd15;
  localparam logic [7:0] KEY_SYM [16] = '{
    8'h31, 8'h32, 8'h33, 8'h2B, 8'h34, 8'h35, 8'h36, 8'h2D,
    8'h37, 8'h38, 8'h39, 8'h2A, 8'h43, 8'h30, 8'h3D, 8'h2F};
  function automatic logic [1:0] onehot_idx(input logic [KP_W-1:0] r);
    return r[3] ? 2'd3 : r[2] ? 2'd2 : r[1] ? 2'd1 : 2'd0;
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for asynchronous level inputs
module sync_2ff
  import keypad_scanner_pkg::*;
#(
  parameter int W = KP_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] meta_q, sync_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end
  assign q_o = sync_q;
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 keypad column scanner with debounce, ghost rejection and valid/ready key output
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int SCAN_DIV     = 4,
  parameter int DEBOUNCE_CNT = 8
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic [KP_W-1:0] Fila,
  output logic [KP_W-1:0] Columna,
  output logic [3:0]      key_code,
  output logic            key_valid,
  input  logic            key_ready,
  output logic            botonApretado
);
  localparam int CW = $clog2((SCAN_DIV > DEBOUNCE_CNT ? SCAN_DIV : DEBOUNCE_CNT) + 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CNT - 1);
  state_e          state_q, state_d;
  logic [1:0]      col_q, col_d;
  logic [CW-1:0]   div_q, div_d, cnt_q, cnt_d;
  logic [KP_W-1:0] pat_q, pat_d, rows_s;
  logic [3:0]      code_q, code_d;
  sync_2ff #(.W(KP_W)) u_sync (.clk_i(Clk), .rst_i(Reset), .d_i(Fila), .q_o(rows_s));
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    pat_d   = pat_q;
    code_d  = code_q;
    case (state_q)
      ST_SCAN: begin
        div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        if (div_q == DIV_LAST && rows_s == '0) col_d = col_q + 2'd1;
        if (div_q == DIV_LAST && rows_s != '0) begin
          pat_d   = rows_s;
          state_d = ST_DEBOUNCE;
        end
      end
      ST_DEBOUNCE: begin
        cnt_d = (rows_s == pat_q && cnt_q != DEB_LAST) ? cnt_q + 1'b1 : '0;
        if (rows_s != pat_q) state_d = ST_SCAN;
        else if (cnt_q == DEB_LAST) begin
          // several rows on one column cannot be resolved to a single key
          state_d = $onehot(pat_q) ? ST_PRESENT : ST_RELEASE;
          code_d  = $onehot(pat_q) ? {onehot_idx(pat_q), col_q} : code_q;
        end
      end
      ST_PRESENT: state_d = key_ready ? ST_RELEASE : ST_PRESENT;
      ST_RELEASE: begin
        cnt_d = (rows_s == '0 && cnt_q != DEB_LAST) ? cnt_q + 1'b1 : '0;
        if (rows_s == '0 && cnt_q == DEB_LAST) begin
          col_d   = col_q + 2'd1;
          state_d = ST_SCAN;
        end
      end
      default: state_d = ST_SCAN;
    endcase
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_SCAN;
      col_q   <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      pat_q   <= '0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
      code_q  <= code_d;
    end
  end
  assign Columna       = 4'b0001 << col_q;
  assign key_code      = code_q;
  assign key_valid     = state_q == ST_PRESENT;
  assign botonApretado = state_q != ST_SCAN;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed keypad scenarios against hand-computed cycle timing
module tb_keypad_scanner;
  logic        clk = 1'b0, rst = 1'b1, key_ready = 1'b0;
  logic [15:0] keys = '0;
  logic [3:0]  fila, columna, key_code, last_code = '0;
  logic        key_valid, boton;
  int          n_vec = 0, n_bad = 0, xfers = 0, valid_cycles = 0, oh_bad = 0;
  always #5 clk = ~clk;
  assign fila = {|(keys[15:12] & columna), |(keys[11:8] & columna),
                 |(keys[7:4] & columna), |(keys[3:0] & columna)};
  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(8)) dut (
    .Clk(clk), .Reset(rst), .Fila(fila), .Columna(columna), .key_code(key_code),
    .key_valid(key_valid), .key_ready(key_ready), .botonApretado(boton));
  always @(negedge clk) begin
    if (!rst) begin
      if (key_valid && key_ready) begin
        xfers++;
        last_code = key_code;
      end
      if (key_valid) valid_cycles++;
      if (!$onehot(columna)) oh_bad++;
    end
  end
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wait_col(input logic [3:0] c);
    int t = 0;
    while (columna !== c && t < 64) begin
      tick();
      t++;
    end
    if (columna !== c) chk("wait_col timeout", {12'd0, columna}, {12'd0, c});
  endtask
  initial begin
    logic [3:0] exp_col;
    tick(2);
    rst = 1'b0;
    chk("rst columna", {12'd0, columna}, 16'h0001);
    chk("rst key_valid", {15'd0, key_valid}, 16'd0);
    chk("rst key_code", {12'd0, key_code}, 16'd0);
    chk("rst boton", {15'd0, boton}, 16'd0);
    // idle scan rotates every 4 cycles
    for (int k = 1; k <= 8; k++) begin
      tick(4);
      exp_col = 4'b0001 << (k % 4);
      chk("idle columna", {12'd0, columna}, {12'd0, exp_col});
    end
    chk("idle no valid", 16'(valid_cycles), 16'd0);
    // row 2 / col 1 held 40 cycles with consumer ready
    key_ready = 1'b1;
    xfers = 0;
    valid_cycles = 0;
    keys = 16'h0200;
    tick(40);
    chk("hold xfers", 16'(xfers), 16'd1);
    chk("hold code", {12'd0, last_code}, 16'd9);
    chk("hold valid cycles", 16'(valid_cycles), 16'd1);
    chk("hold boton", {15'd0, boton}, 16'd1);
    keys = '0;
    tick(9);
    chk("release boton still", {15'd0, boton}, 16'd1);
    tick();
    chk("release boton low", {15'd0, boton}, 16'd0);
    chk("release next col", {12'd0, columna}, 16'h0004);
    // 5-cycle bounce on row 1 / col 0
    xfers = 0;
    wait_col(4'b1000);
    wait_col(4'b0001);
    keys = 16'h0010;
    tick(5);
    chk("bounce debouncing", {15'd0, boton}, 16'd1);
    keys = '0;
    tick(3);
    chk("bounce back scan", {15'd0, boton}, 16'd0);
    chk("bounce same col", {12'd0, columna}, 16'h0001);
    tick(4);
    chk("bounce col advances", {12'd0, columna}, 16'h0002);
    chk("bounce xfers", 16'(xfers), 16'd0);
    // row 0 / col 3 with consumer stalled, key released while pending
    key_ready = 1'b0;
    xfers = 0;
    wait_col(4'b0100);
    wait_col(4'b1000);
    keys = 16'h0008;
    tick(11);
    chk("stall pre valid", {15'd0, key_valid}, 16'd0);
    tick();
    chk("stall valid", {15'd0, key_valid}, 16'd1);
    chk("stall code", {12'd0, key_code}, 16'd3);
    tick(8);
    keys = '0;
    tick(30);
    chk("stall held valid", {15'd0, key_valid}, 16'd1);
    chk("stall held code", {12'd0, key_code}, 16'd3);
    key_ready = 1'b1;
    tick();
    chk("stall valid drops", {15'd0, key_valid}, 16'd0);
    tick(7);
    chk("stall release boton", {15'd0, boton}, 16'd1);
    tick();
    chk("stall scan col0", {12'd0, columna}, 16'h0001);
    chk("stall xfers", 16'(xfers), 16'd1);
    chk("stall xfer code", {12'd0, last_code}, 16'd3);
    // ghost: rows 0 and 1 on col 2
    xfers = 0;
    wait_col(4'b0010);
    wait_col(4'b0100);
    keys = 16'h0044;
    tick(12);
    chk("ghost boton", {15'd0, boton}, 16'd1);
    chk("ghost no valid", {15'd0, key_valid}, 16'd0);
    tick(8);
    keys = '0;
    tick(9);
    chk("ghost col held", {12'd0, columna}, 16'h0004);
    tick();
    chk("ghost resume col3", {12'd0, columna}, 16'h0008);
    chk("ghost boton low", {15'd0, boton}, 16'd0);
    chk("ghost xfers", 16'(xfers), 16'd0);
    // reset while a key is pending
    key_ready = 1'b0;
    wait_col(4'b1000);
    wait_col(4'b0001);
    keys = 16'h1000;
    tick(12);
    chk("pend valid", {15'd0, key_valid}, 16'd1);
    chk("pend code", {12'd0, key_code}, 16'd12);
    rst = 1'b1;
    tick();
    chk("mid rst valid", {15'd0, key_valid}, 16'd0);
    chk("mid rst columna", {12'd0, columna}, 16'h0001);
    chk("mid rst boton", {15'd0, boton}, 16'd0);
    chk("mid rst code", {12'd0, key_code}, 16'd0);
    rst = 1'b0;
    keys = '0;
    key_ready = 1'b1;
    xfers = 0;
    tick(40);
    chk("mid rst no xfer", 16'(xfers), 16'd0);
    chk("onehot columna", 16'(oh_bad), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 4: Clk cycles each column is driven before rows are sampled (>=2).
REQ-002 Parameter DEBOUNCE_CNT, default 8: consecutive stable samples required for press/release acceptance (>=1).
REQ-003 Clk  input  1  sole clock, rising edge; one clock, all state in this domain.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Fila  input  4  keypad row lines, active-high, asynchronous to Clk.
REQ-006 Columna  output  4  column drive, one-hot, active-high.
REQ-007 key_code  output  4  pressed key index = row*4 + column.
REQ-008 key_valid  output  1  key_code valid, held until accepted.
REQ-009 key_ready  input  1  consumer accepts key when high with key_valid.
REQ-010 botonApretado  output  1  high while a debounced key is held (DEBOUNCE through RELEASE states).

Function
REQ-011 Fila SHALL pass a 2-flop synchronizer; all decisions SHALL use the synchronized value (rows_s).
REQ-012 FSM states SHALL be SCAN, DEBOUNCE, PRESENT, RELEASE.
REQ-013 SCAN: Columna = one-hot of col index; a divider counts SCAN_DIV cycles; on its last cycle, rows_s == 0 advances col (3 wraps to 0), rows_s != 0 latches rows_s and col and enters DEBOUNCE.
REQ-014 DEBOUNCE: column held; counter increments each cycle rows_s equals the latched pattern; any mismatch (including zero) SHALL return to SCAN on the same column with counters cleared.
REQ-015 DEBOUNCE: counter reaching DEBOUNCE_CNT with exactly one row bit set SHALL enter PRESENT with key_code = row*4+col.
REQ-016 DEBOUNCE: counter reaching DEBOUNCE_CNT with more than one row bit set (ghost/multi-key) SHALL enter RELEASE without asserting key_valid.
REQ-017 PRESENT: key_valid = 1, key_code stable; transfer occurs on the cycle key_valid && key_ready; next state RELEASE and key_valid deasserts the following cycle.
REQ-018 PRESENT SHALL persist indefinitely while key_ready = 0, even if the key is released.
REQ-019 RELEASE: column held; counter counts consecutive cycles rows_s == 0, any nonzero sample clears it; reaching DEBOUNCE_CNT SHALL enter SCAN at col+1 (wrap).
REQ-020 Exactly one key_valid transfer SHALL occur per debounced press, regardless of hold duration.
REQ-021 key_ready while key_valid = 0 SHALL have no effect.
REQ-022 Columna SHALL be one-hot in every cycle after reset; never zero, never multi-hot.
REQ-023 Counters SHALL be sized clog2(max(SCAN_DIV, DEBOUNCE_CNT)+1) and saturate-free (cleared on every state change).

Reset
REQ-024 Reset SHALL yield: state SCAN, col 0, Columna = 4'b0001, key_code = 0, key_valid = 0, botonApretado = 0, all counters and synchronizer flops 0.
REQ-025 Reset asserted mid-operation (any state, including PRESENT with pending key) SHALL take effect on the next edge and discard the pending key.

Structure
REQ-026 A shared package SHALL hold the state enum, column/row width constant (4), and key_code-to-calculator symbol mapping constants (digits, operators, equals, clear).
REQ-027 The 2-flop synchronizer SHALL be a separate sub-module, sync_2ff, instantiated 4 bits wide.
REQ-028 No other sub-modules; FSM, divider and debounce counter reside in keypad_scanner.

Verification (SCAN_DIV=4, DEBOUNCE_CNT=8)
REQ-029 Reset, Fila=0 for 32 cycles -> Columna cycles 0001,0010,0100,1000,0001 every 4 cycles; key_valid stays 0.
REQ-030 Key row 2/col 1 held 40 cycles, key_ready=1 -> single key_valid pulse, key_code=9; botonApretado high until 8 zero samples after release.
REQ-031 Key pressed 5 cycles then released (bounce) -> no key_valid; scanning resumes on same column.
REQ-032 Key row 0/col 3 pressed, key_ready=0 for 50 cycles, key released at cycle 20 -> key_valid held with key_code=3 until key_ready=1, one transfer only.
REQ-033 Rows 0 and 1 both high on col 2 -> no key_valid; after release of both, scan resumes at col 3.
REQ-034 Reset asserted during PRESENT -> next cycle key_valid=0, Columna=0001, botonApretado=0.
